hamm_secded_dec_pipe: RTL and testbench

Parametrised, pipelined Hamming SECDED decoder for any data width. It accepts one codeword plus an overall-parity bit per cycle on a valid/ready stream and returns corrected data with a per-beat syndrome and error classification. It also keeps saturating single- and double-error counters and a sticky uncorrectable flag for status readout. It replaces fixed 8-bit combinational decoding in the datapath behind the storage/link receive path.

---
 rtl/hamm_pkg.sv | 27 ++
 rtl/hamm_syndrome.sv | 21 ++
 rtl/hamm_secded_dec_pipe.sv | 150 +++++++++++++++
 tb/tb_hamm_secded_dec_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamm_pkg.sv
// Shared Hamming SECDED definitions: code geometry helpers and the per-beat
// error classification used by the decoder pipeline.
package hamm_pkg;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    PAR_ERR = 2'd1,
    SBE_FIX = 2'd2,
    DBE     = 2'd3
  } hamm_class_e;

  // Smallest r with 2^r >= data_w + r + 1; the descending scan keeps the minimum.
  function automatic int hamm_r(input int data_w);
    int r;
    r = 0;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  // 1-based positions that are not powers of two carry data.
  function automatic bit hamm_is_data_pos(input int pos);
    return (pos & (pos - 1)) != 0;
  endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational Hamming syndrome and overall-parity mismatch for an N-bit
// codeword, where bit i sits at 1-based position i+1.
module hamm_syndrome #(
  parameter int N = 12,
  parameter int R = $clog2(N + 1)
) (
  input  logic [N-1:0] code,
  input  logic         parity,
  output logic [R-1:0] syn,
  output logic         pm
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) syn = syn ^ R'(i + 1);
    end
    pm = parity ^ (^code);
  end

endmodule

// File: rtl/hamm_secded_dec_pipe.sv
// Two-stage pipelined Hamming SECDED decoder on a valid/ready stream, with
// saturating error counters and a sticky uncorrectable flag.
module hamm_secded_dec_pipe
  import hamm_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int R      = hamm_r(DATA_W),
  localparam int N      = DATA_W + R
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_sbe,
  output logic              out_dbe,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count,
  output logic              dbe_sticky
);

  function automatic logic [DATA_W-1:0] extract_data(input logic [N-1:0] cw);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if (hamm_is_data_pos(pos)) begin
        d[k] = cw[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  logic              adv;
  logic              hs;
  logic [R-1:0]      syn_c;
  logic              pm_c;
  logic              vld_p1;
  logic [N-1:0]      code_p1;
  logic [R-1:0]      syn_p1;
  logic              pm_p1;
  hamm_class_e       cls_c;
  logic [N-1:0]      fixed_c;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic [R-1:0]      syn_p2;
  logic              sbe_p2;
  logic              dbe_p2;
  logic [CNT_W-1:0]  sbe_cnt;
  logic [CNT_W-1:0]  dbe_cnt;
  logic              sticky;

  assign adv      = !vld_p2 || out_ready;
  assign in_ready = adv;
  assign hs       = vld_p2 && out_ready;

  hamm_syndrome #(.N(N), .R(R)) u_syndrome (
    .code   (in_code),
    .parity (in_parity),
    .syn    (syn_c),
    .pm     (pm_c)
  );

  // Stage 1: register codeword, syndrome and parity mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      code_p1 <= in_code;
      syn_p1  <= syn_c;
      pm_p1   <= pm_c;
    end
  end

  // Classify and correct; out-of-range syndromes are never used to flip a bit
  always_comb begin
    cls_c = DBE;
    if (syn_p1 == '0) begin
      cls_c = pm_p1 ? PAR_ERR : CLEAN;
    end else if (pm_p1 && (int'(syn_p1) <= N)) begin
      cls_c = SBE_FIX;
    end
    fixed_c = code_p1;
    if (cls_c == SBE_FIX) begin
      for (int i = 0; i < N; i++) begin
        if (int'(syn_p1) == i + 1) fixed_c[i] = ~code_p1[i];
      end
    end
  end

  // Stage 2: register corrected data, syndrome and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      syn_p2  <= '0;
      sbe_p2  <= 1'b0;
      dbe_p2  <= 1'b0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      data_p2 <= extract_data(fixed_c);
      syn_p2  <= syn_p1;
      sbe_p2  <= vld_p1 && ((cls_c == PAR_ERR) || (cls_c == SBE_FIX));
      dbe_p2  <= vld_p1 && (cls_c == DBE);
    end
  end

  // Status: counts only delivered beats; clear beats a coincident handshake
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
      sticky  <= 1'b0;
    end else if (hs) begin
      sbe_cnt <= sat_inc(sbe_cnt, sbe_p2);
      dbe_cnt <= sat_inc(dbe_cnt, dbe_p2);
      sticky  <= sticky || dbe_p2;
    end
  end

  assign out_valid    = vld_p2;
  assign out_data     = data_p2;
  assign out_syndrome = syn_p2;
  assign out_sbe      = sbe_p2;
  assign out_dbe      = dbe_p2;
  assign sbe_count    = sbe_cnt;
  assign dbe_count    = dbe_cnt;
  assign dbe_sticky   = sticky;

endmodule

// File: tb/tb_hamm_secded_dec_pipe.sv
// Directed bench for hamm_secded_dec_pipe (DATA_W=8, CNT_W=2) with a
// behavioural SECDED scoreboard checked every cycle.
module tb_hamm_secded_dec_pipe;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int R      = 4;
  localparam int N      = 12;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_code;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0]      out_syndrome;
  logic              out_sbe;
  logic              out_dbe;
  logic              cnt_clr;
  logic [CNT_W-1:0]  sbe_count;
  logic [CNT_W-1:0]  dbe_count;
  logic              dbe_sticky;

  always #5 clk = ~clk;

  hamm_secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .in_parity    (in_parity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_sbe      (out_sbe),
    .out_dbe      (out_dbe),
    .cnt_clr      (cnt_clr),
    .sbe_count    (sbe_count),
    .dbe_count    (dbe_count),
    .dbe_sticky   (dbe_sticky)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] syn;
    logic       sbe;
    logic       dbe;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    m_sbe = 0;
  int    m_dbe = 0;
  bit    m_sticky = 0;
  bit    synced = 0;
  bit    rand_rdy = 0;
  bit    prev_stall = 0;
  logic [7:0] pv_data;
  logic [3:0] pv_syn;
  logic       pv_sbe, pv_dbe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode straight from the SECDED rules: XOR of set positions, overall parity
  function automatic beat_t model(input logic [11:0] cw, input logic par);
    beat_t b;
    int syn;
    int ones;
    int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [11:0] fx;
    logic pm;
    syn = 0;
    ones = 0;
    for (int p = 1; p <= 12; p++) begin
      if (cw[p-1]) begin
        syn = syn ^ p;
        ones++;
      end
    end
    pm = par ^ ones[0];
    fx = cw;
    b.sbe = 1'b0;
    b.dbe = 1'b0;
    if (syn == 0) b.sbe = pm;
    else if (pm && syn <= 12) begin
      fx[syn-1] = ~fx[syn-1];
      b.sbe = 1'b1;
    end else b.dbe = 1'b1;
    for (int k = 0; k < 8; k++) b.data[k] = fx[dpos[k]-1];
    b.syn = syn[3:0];
    return b;
  endfunction

  // Scoreboard: values at the falling edge are what the next rising edge commits
  always @(negedge clk) begin
    beat_t e;
    if (synced) begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("sbe_count", sbe_count, m_sbe);
      chk("dbe_count", dbe_count, m_dbe);
      chk("dbe_sticky", dbe_sticky, m_sticky);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pv_data);
        chk("stall_syn", out_syndrome, pv_syn);
        chk("stall_sbe", out_sbe, pv_sbe);
        chk("stall_dbe", out_dbe, pv_dbe);
      end
    end
    if (rst) begin
      exp_q.delete();
      m_sbe = 0;
      m_dbe = 0;
      m_sticky = 0;
      prev_stall = 0;
      synced = 1;
    end else if (synced) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_beat: got data 0x%0h, want no beat at %0t", out_data, $time);
        end else begin
          n_cmp--;
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_syn", out_syndrome, e.syn);
          chk("beat_sbe", out_sbe, e.sbe);
          chk("beat_dbe", out_dbe, e.dbe);
          if (e.sbe && m_sbe < CMAX) m_sbe++;
          if (e.dbe && m_dbe < CMAX) m_dbe++;
          if (e.dbe) m_sticky = 1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_code, in_parity));
      if (cnt_clr) begin
        m_sbe = 0;
        m_dbe = 0;
        m_sticky = 0;
      end
      prev_stall = out_valid && !out_ready;
      pv_data = out_data;
      pv_syn = out_syndrome;
      pv_sbe = out_sbe;
      pv_dbe = out_dbe;
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the beat until accepted; called and returns 1 time unit after a rising edge
  task automatic send_beat(input logic [11:0] c, input logic p);
    bit acc;
    acc = 0;
    in_code = c;
    in_parity = p;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", acc, 1);
  endtask

  task automatic do_beat(input logic [11:0] c, input logic p, input logic [7:0] d,
                         input logic [3:0] s, input logic sbe, input logic dbe);
    in_code = c;
    in_parity = p;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_t1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_t2_valid", out_valid, 1);
    chk("lit_data", out_data, d);
    chk("lit_syn", out_syndrome, s);
    chk("lit_sbe", out_sbe, sbe);
    chk("lit_dbe", out_dbe, dbe);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] codes[10] = '{12'hA27, 12'hA07, 12'hA27, 12'hA06, 12'hAAE,
                               12'h000, 12'hFFF, 12'h5A5, 12'hA26, 12'h123};
    logic [9:0]  pars = 10'b0110010100;
    int wait_cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    in_parity = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    idle(3);
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_syn", out_syndrome, 0);
    chk("rst_out_sbe", out_sbe, 0);
    chk("rst_out_dbe", out_dbe, 0);
    chk("rst_sbe_count", sbe_count, 0);
    chk("rst_dbe_count", dbe_count, 0);
    chk("rst_sticky", dbe_sticky, 0);
    chk("rst_in_ready", in_ready, 1);

    do_beat(12'hA27, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b0);
    idle(1);
    chk("clean_sbe_count", sbe_count, 0);
    do_beat(12'hA07, 1'b0, 8'hA5, 4'd6, 1'b1, 1'b0);
    idle(1);
    chk("sbe_count_1", sbe_count, 1);
    do_beat(12'hA27, 1'b1, 8'hA5, 4'd0, 1'b1, 1'b0);
    idle(1);
    chk("sbe_count_2", sbe_count, 2);
    do_beat(12'hA06, 1'b0, 8'hA1, 4'd7, 1'b0, 1'b1);
    idle(1);
    chk("dbe_count_1", dbe_count, 1);
    chk("sticky_set", dbe_sticky, 1);
    do_beat(12'hAAE, 1'b0, 8'hA5, 4'd13, 1'b0, 1'b1);
    idle(1);
    chk("dbe_count_2", dbe_count, 2);
    idle(5);
    chk("sticky_held", dbe_sticky, 1);

    rand_rdy = 1;
    for (int i = 0; i < 10; i++) send_beat(codes[i], pars[i]);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      idle(1);
      wait_cnt++;
    end
    rand_rdy = 0;
    idle(1);
    out_ready = 1'b1;
    idle(3);
    chk("stream_drained", exp_q.size(), 0);

    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    chk("clr_sbe_count", sbe_count, 0);
    chk("clr_dbe_count", dbe_count, 0);
    chk("clr_sticky", dbe_sticky, 0);

    for (int i = 0; i < 5; i++) send_beat(12'hA07, 1'b0);
    in_valid = 1'b0;
    idle(4);
    chk("sbe_saturated", sbe_count, 3);

    do_beat(12'hA07, 1'b0, 8'hA5, 4'd6, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    chk("clr_wins_hs", sbe_count, 0);
    idle(1);
    chk("clr_wins_hold", sbe_count, 0);

    send_beat(12'hA27, 1'b0);
    send_beat(12'hA07, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    idle(1);
    chk("midrst_valid", out_valid, 0);
    rst = 1'b0;
    idle(3);
    chk("midrst_flushed", out_valid, 0);
    chk("midrst_sbe_count", sbe_count, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
